// File: rtl/alu_result_stage_if.sv
// ---------------------------------------------------------------------------
// alu_result_stage_if
//   Bundles the upstream (adder/subtractor -> stage) and downstream
//   (stage -> consumer) streams of the ALU result stage.
//
//   Handshake semantics for both streams: a transfer happens on a rising
//   clock edge where valid & ready are both 1. A producer holding valid=1
//   keeps its payload stable until that transfer. Ready may be asserted
//   without valid.
//
//   Signals
//     in_valid / in_ready    upstream handshake
//     in_a, in_b, in_k       operands and mode (0 = a+b, 1 = a-b)
//     in_sum, in_cout        adder/subtractor result and carry-out
//     out_valid / out_ready  downstream handshake
//     out_result             registered sum
//     out_c/z/n/v            carry, zero, negative, signed-overflow flags
//
//   Modports
//     slave   the result stage itself (consumes in_*, produces out_*)
//     master  the environment around the stage (drives in_*, out_ready)
// ---------------------------------------------------------------------------
interface alu_result_stage_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_k;
  logic [WIDTH-1:0] in_sum;
  logic             in_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_c;
  logic             out_z;
  logic             out_n;
  logic             out_v;

  modport slave (
    input  in_valid, in_a, in_b, in_k, in_sum, in_cout, out_ready,
    output in_ready, out_valid, out_result, out_c, out_z, out_n, out_v
  );

  modport master (
    output in_valid, in_a, in_b, in_k, in_sum, in_cout, out_ready,
    input  in_ready, out_valid, out_result, out_c, out_z, out_n, out_v
  );
endinterface

// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//   Registered output stage behind the 8-bit adder/subtractor. Captures each
//   accepted result together with its C/Z/N/V flags into a two-entry skid
//   buffer (main = output register, skid = overflow entry) so downstream
//   backpressure never drops or duplicates a result. Also keeps a sticky
//   overflow flag and a wrapping delivered-result counter.
//
//   Ports
//     clk         system clock, all state on rising edge
//     rst_n       asynchronous active-low reset
//     bus         alu_result_stage_if.slave: upstream/downstream streams
//     clr         synchronous clear of sticky_v and result_cnt
//     sticky_v    set once any delivered result had V=1
//     result_cnt  number of delivered results, wraps
//     state       current buffer state (EMPTY/ONE/TWO) for observation
//
//   Handshake: accept = in_valid & in_ready, deliver = out_valid & out_ready,
//   both evaluated at the rising edge. in_ready is a register that is 0 only
//   while both entries are occupied; out_valid is 1 whenever main holds an
//   entry, and main does not change while out_valid & ~out_ready.
// ---------------------------------------------------------------------------
module alu_result_stage #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_result_stage_if.slave bus,
  input  logic             clr,
  output logic             sticky_v,
  output logic [CNT_W-1:0] result_cnt,
  output logic [1:0]       state
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  localparam int MSB = WIDTH - 1;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             c;
    logic             z;
    logic             n;
    logic             v;
  } entry_t;

  logic [1:0]       state_q, state_d;
  logic             in_ready_q;
  entry_t           main_q, skid_q;
  entry_t           in_entry;
  logic             accept, deliver;
  logic             load_main, load_skid, main_from_skid;
  logic             sticky_q;
  logic [CNT_W-1:0] cnt_q;

  // Flags derived from the raw adder inputs. For subtraction the operand
  // signs must differ for overflow to be possible; for addition they must
  // match. In both cases overflow shows as the sum sign leaving a's sign.
  always_comb begin
    in_entry        = '0;
    in_entry.result = bus.in_sum;
    in_entry.c      = bus.in_cout;
    in_entry.z      = ~|bus.in_sum;
    in_entry.n      = bus.in_sum[MSB];
    if (bus.in_k)
      in_entry.v = (bus.in_a[MSB] != bus.in_b[MSB]) &
                   (bus.in_sum[MSB] != bus.in_a[MSB]);
    else
      in_entry.v = (bus.in_a[MSB] == bus.in_b[MSB]) &
                   (bus.in_sum[MSB] != bus.in_a[MSB]);
  end

  assign accept  = bus.in_valid & in_ready_q;
  assign deliver = (state_q != EMPTY) & bus.out_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = TWO;
        end else if (deliver) begin
          state_d   = EMPTY;
        end
      end
      TWO: begin
        // in_ready is 0 here, so accept cannot occur.
        if (deliver) begin
          main_from_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
      if (load_main)
        main_q <= in_entry;
      else if (main_from_skid)
        main_q <= skid_q;
      if (load_skid)
        skid_q <= in_entry;
    end
  end

  // clr beats a delivery for the counter, but a delivered overflow beats
  // clr for the sticky flag so an overflow is never silently lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (clr)
        cnt_q <= '0;
      else if (deliver)
        cnt_q <= cnt_q + 1'b1;

      if (deliver && main_q.v)
        sticky_q <= 1'b1;
      else if (clr)
        sticky_q <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = (state_q != EMPTY);
  assign bus.out_result = main_q.result;
  assign bus.out_c      = main_q.c;
  assign bus.out_z      = main_q.z;
  assign bus.out_n      = main_q.n;
  assign bus.out_v      = main_q.v;

  assign sticky_v   = sticky_q;
  assign result_cnt = cnt_q;
  assign state      = state_q;

endmodule
